// File: rtl/reg_bank_shadow.sv
// Shadow/active register bank: bus writes land in shadow registers,
// commit copies every shadow into the active bank driven onto cfg_data_out.
//
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   reg_we/reg_re - write/read strobes for reg_addr
//   reg_addr      - register address (hit window BASE_ADDR..+NREG-1)
//   reg_data_in   - write data
//   commit        - copy all shadows into the active bank
//   reg_data_out  - registered read data (0 when no valid read)
//   reg_rvalid    - read data valid, one cycle after a hit read
//   cfg_data_out  - active bank, register i at [i*DW +: DW]
//   cfg_update    - one-cycle pulse with newly committed values
//   pending       - shadow written since last commit
module reg_bank_shadow #(
  parameter int unsigned    DW        = 16,
  parameter int unsigned    NREG      = 4,
  parameter int unsigned    ABW       = 8,
  parameter int unsigned    BASE_ADDR = 0,
  parameter logic [DW-1:0]  RST_VAL   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [ABW-1:0]     reg_addr,
  input  logic [DW-1:0]      reg_data_in,
  input  logic               commit,
  output logic [DW-1:0]      reg_data_out,
  output logic               reg_rvalid,
  output logic [NREG*DW-1:0] cfg_data_out,
  output logic               cfg_update,
  output logic               pending
);

  localparam int unsigned IW =
    (NREG > 1) ? $clog2(NREG) : 1;

  logic [NREG-1:0][DW-1:0] shadow;
  logic [NREG-1:0][DW-1:0] active;

  logic [31:0]   off;
  logic          hit;
  logic [IW-1:0] idx;
  logic          wr_hit;
  logic          rd_hit;

  // Addresses below BASE_ADDR wrap to huge offsets and miss.
  assign off    = 32'(reg_addr) - BASE_ADDR;
  assign hit    = (off < NREG);
  assign idx    = off[IW-1:0];
  assign wr_hit = reg_we & hit;
  assign rd_hit = reg_re & hit;

  assign cfg_data_out = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= {NREG{RST_VAL}};
      active       <= {NREG{RST_VAL}};
      reg_data_out <= '0;
      reg_rvalid   <= 1'b0;
      cfg_update   <= 1'b0;
      pending      <= 1'b0;
    end else begin
      // Reads and commits see the pre-write shadow.
      reg_rvalid   <= rd_hit;
      reg_data_out <= rd_hit ? shadow[idx] : '0;
      cfg_update   <= commit;
      if (commit)
        active <= shadow;
      if (wr_hit)
        shadow[idx] <= reg_data_in;
      // A write in the commit cycle is not yet committed.
      if (wr_hit)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Self-checking bench for reg_bank_shadow.
// Reference model kept as plain arrays updated per clock.
module tb_reg_bank_shadow;

  localparam int DW   = 16;
  localparam int NREG = 4;
  localparam int ABW  = 8;
  localparam int BASE = 16;
  localparam logic [DW-1:0] RSTV = 16'h5A3C;

  logic               clk;
  logic               rst_n;
  logic               reg_we;
  logic               reg_re;
  logic [ABW-1:0]     reg_addr;
  logic [DW-1:0]      reg_data_in;
  logic               commit;
  logic [DW-1:0]      reg_data_out;
  logic               reg_rvalid;
  logic [NREG*DW-1:0] cfg_data_out;
  logic               cfg_update;
  logic               pending;

  int checks;
  int failures;

  logic [DW-1:0] m_sh  [NREG];
  logic [DW-1:0] m_act [NREG];
  logic          m_pend;
  logic [DW-1:0] m_rd;
  logic          m_rv;
  logic          m_upd;

  reg_bank_shadow #(
    .DW(DW), .NREG(NREG), .ABW(ABW),
    .BASE_ADDR(BASE), .RST_VAL(RSTV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_we(reg_we), .reg_re(reg_re),
    .reg_addr(reg_addr),
    .reg_data_in(reg_data_in),
    .commit(commit),
    .reg_data_out(reg_data_out),
    .reg_rvalid(reg_rvalid),
    .cfg_data_out(cfg_data_out),
    .cfg_update(cfg_update),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREG*DW-1:0] exp_cfg();
    logic [NREG*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NREG; k++)
      v[k*DW +: DW] = m_act[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) begin
      m_sh[k]  = RSTV;
      m_act[k] = RSTV;
    end
    m_pend = 1'b0;
    m_rd   = '0;
    m_rv   = 1'b0;
    m_upd  = 1'b0;
  endtask

  task automatic idle_inputs();
    reg_we      = 1'b0;
    reg_re      = 1'b0;
    reg_addr    = '0;
    reg_data_in = '0;
    commit      = 1'b0;
  endtask

  // Drive one cycle, advance the model, return at posedge+1.
  task automatic step(input logic we, input logic re,
                      input int addr,
                      input logic [DW-1:0] din,
                      input logic cm);
    bit hit;
    int i;
    reg_we      = we;
    reg_re      = re;
    reg_addr    = ABW'(addr);
    reg_data_in = din;
    commit      = cm;
    @(posedge clk);
    hit = (addr >= BASE) && (addr < BASE + NREG);
    i   = addr - BASE;
    m_rv = re && hit;
    m_rd = '0;
    if (re && hit) m_rd = m_sh[i];
    if (cm)
      for (int k = 0; k < NREG; k++) m_act[k] = m_sh[k];
    m_upd = cm;
    if (we && hit) begin
      m_sh[i] = din;
      m_pend  = 1'b1;
    end else if (cm) begin
      m_pend = 1'b0;
    end
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (cfg_data_out !== exp_cfg()) begin
      failures++;
      $display("FAIL rst_cfg got=%h exp=%h",
               cfg_data_out, exp_cfg());
    end
    checks++;
    if ({reg_rvalid, cfg_update, pending} !== 3'b000
        || reg_data_out !== '0) begin
      failures++;
      $display("FAIL rst_outs got=%b%b%b/%h exp=000/0",
               reg_rvalid, cfg_update, pending, reg_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < NREG; a++) begin
      step(0, 1, BASE + a, '0, 0);
      checks++;
      if (reg_data_out !== RSTV || reg_rvalid !== 1'b1) begin
        failures++;
        $display("FAIL rst_read%0d got=%h/%b exp=%h/1",
                 a, reg_data_out, reg_rvalid, RSTV);
      end
    end
  endtask

  task automatic test_write_read();
    step(1, 0, BASE + 1, 16'hA5A5, 0);
    checks++;
    if (pending !== 1'b1
        || cfg_data_out[DW +: DW] !== RSTV) begin
      failures++;
      $display("FAIL wr_pend got=%b/%h exp=1/%h",
               pending, cfg_data_out[DW +: DW], RSTV);
    end
    step(0, 1, BASE + 1, '0, 0);
    checks++;
    if (reg_data_out !== 16'hA5A5 || reg_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL wr_read got=%h/%b exp=a5a5/1",
               reg_data_out, reg_rvalid);
    end
  endtask

  task automatic test_commit();
    step(0, 0, 0, '0, 1);
    checks++;
    if (cfg_data_out[DW +: DW] !== 16'hA5A5
        || cfg_update !== 1'b1 || pending !== 1'b0) begin
      failures++;
      $display("FAIL commit got=%h/%b/%b exp=a5a5/1/0",
               cfg_data_out[DW +: DW], cfg_update, pending);
    end
    step(0, 0, 0, '0, 0);
    checks++;
    if (cfg_update !== 1'b0 || cfg_data_out !== exp_cfg()) begin
      failures++;
      $display("FAIL commit_pulse got=%b/%h exp=0/%h",
               cfg_update, cfg_data_out, exp_cfg());
    end
  endtask

  task automatic test_write_commit();
    step(1, 0, BASE, 16'h0001, 0);
    step(1, 0, BASE, 16'h1234, 1);
    checks++;
    if (cfg_data_out[0 +: DW] !== 16'h0001
        || pending !== 1'b1 || cfg_update !== 1'b1) begin
      failures++;
      $display("FAIL wr_commit got=%h/%b/%b exp=0001/1/1",
               cfg_data_out[0 +: DW], pending, cfg_update);
    end
    step(0, 1, BASE, '0, 0);
    checks++;
    if (reg_data_out !== 16'h1234) begin
      failures++;
      $display("FAIL wr_commit_shadow got=%h exp=1234",
               reg_data_out);
    end
  endtask

  task automatic test_miss();
    step(0, 0, 0, '0, 1);
    step(1, 1, BASE + NREG, 16'hDEAD, 0);
    checks++;
    if (reg_rvalid !== 1'b0 || reg_data_out !== '0
        || pending !== 1'b0) begin
      failures++;
      $display("FAIL miss_hi got=%b/%h/%b exp=0/0/0",
               reg_rvalid, reg_data_out, pending);
    end
    step(1, 1, BASE - 1, 16'hBEEF, 0);
    checks++;
    if (reg_rvalid !== 1'b0 || reg_data_out !== '0
        || pending !== 1'b0) begin
      failures++;
      $display("FAIL miss_lo got=%b/%h/%b exp=0/0/0",
               reg_rvalid, reg_data_out, pending);
    end
    for (int a = 0; a < NREG; a++) begin
      step(0, 1, BASE + a, '0, 0);
      checks++;
      if (reg_data_out !== m_rd) begin
        failures++;
        $display("FAIL miss_shadow%0d got=%h exp=%h",
                 a, reg_data_out, m_rd);
      end
    end
    checks++;
    if (cfg_data_out !== exp_cfg()) begin
      failures++;
      $display("FAIL miss_cfg got=%h exp=%h",
               cfg_data_out, exp_cfg());
    end
  endtask

  task automatic test_same_cycle_rw();
    step(1, 0, BASE + 2, 16'h0F0F, 0);
    step(1, 1, BASE + 2, 16'hF0F0, 0);
    checks++;
    if (reg_data_out !== 16'h0F0F) begin
      failures++;
      $display("FAIL rw_same got=%h exp=0f0f", reg_data_out);
    end
    step(0, 1, BASE + 2, '0, 0);
    checks++;
    if (reg_data_out !== 16'hF0F0) begin
      failures++;
      $display("FAIL rw_after got=%h exp=f0f0", reg_data_out);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    checks++;
    if (cfg_update !== 1'b1 || pending !== 1'b0
        || cfg_data_out !== exp_cfg()) begin
      failures++;
      $display("FAIL b2b got=%b/%b/%h exp=1/0/%h",
               cfg_update, pending, cfg_data_out, exp_cfg());
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, BASE + 3, 16'h7777, 0);
    #2;
    reg_we      = 1'b1;
    reg_addr    = ABW'(BASE + 3);
    reg_data_in = 16'h8888;
    commit      = 1'b1;
    rst_n       = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cfg_data_out !== exp_cfg() || pending !== 1'b0
        || cfg_update !== 1'b0 || reg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%b/%b/%b exp=%h/0/0/0",
               cfg_data_out, pending, cfg_update,
               reg_rvalid, exp_cfg());
    end
    @(posedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, BASE + 3, 16'h4321, 0);
    checks++;
    if (cfg_update !== 1'b0 || pending !== 1'b1
        || cfg_data_out !== exp_cfg()) begin
      failures++;
      $display("FAIL post_rst got=%b/%b/%h exp=0/1/%h",
               cfg_update, pending, cfg_data_out, exp_cfg());
    end
    step(0, 1, BASE + 3, '0, 0);
    checks++;
    if (reg_data_out !== 16'h4321) begin
      failures++;
      $display("FAIL post_rst_wr got=%h exp=4321", reg_data_out);
    end
  endtask

  task automatic test_random();
    int addr;
    for (int n = 0; n < 300; n++) begin
      addr = BASE - 2 + int'($urandom_range(NREG + 3));
      step(1'($urandom), 1'($urandom), addr,
           DW'($urandom), ($urandom_range(3) == 0));
      checks++;
      if (reg_data_out !== m_rd || reg_rvalid !== m_rv
          || cfg_update !== m_upd || pending !== m_pend
          || cfg_data_out !== exp_cfg()) begin
        failures++;
        $display("FAIL rand%0d got=%h/%b/%b/%b/%h exp=%h/%b/%b/%b/%h",
                 n, reg_data_out, reg_rvalid, cfg_update,
                 pending, cfg_data_out, m_rd, m_rv, m_upd,
                 m_pend, exp_cfg());
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_commit();
    test_write_commit();
    test_miss();
    test_same_cycle_rw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_shadow.md
REG_BANK_SHADOW -- requirements
Module: reg_bank_shadow

Interface
REQ-001 SHALL have parameter DW, default 16: data width of each register.
REQ-002 SHALL have parameter NREG, default 4: number of registers, legal range 1..256.
REQ-003 SHALL have parameter ABW, default 8: width of the register address bus.
REQ-004 SHALL have parameter BASE_ADDR, default 0: address of register index 0.
REQ-005 SHALL have parameter RST_VAL, default 0 (DW bits): reset value of every shadow and active register.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port reg_we, input, 1 bit: write strobe.
REQ-009 SHALL have port reg_re, input, 1 bit: read strobe.
REQ-010 SHALL have port reg_addr, input, ABW bits: register address.
REQ-011 SHALL have port reg_data_in, input, DW bits: write data.
REQ-012 SHALL have port commit, input, 1 bit: copy all shadow registers to the active registers.
REQ-013 SHALL have port reg_data_out, output, DW bits: registered read data.
REQ-014 SHALL have port reg_rvalid, output, 1 bit: read data valid.
REQ-015 SHALL have port cfg_data_out, output, NREG*DW bits: active registers; register i occupies bits [i*DW +: DW].
REQ-016 SHALL have port cfg_update, output, 1 bit: pulse marking newly committed active values.
REQ-017 SHALL have port pending, output, 1 bit: shadow written since the last commit.

Function
REQ-018 SHALL declare an address hit when BASE_ADDR <= reg_addr < BASE_ADDR+NREG; index = reg_addr-BASE_ADDR.
REQ-019 SHALL, on reg_we with hit, load reg_data_in into shadow[index] at the clock edge; a write that misses SHALL change no state.
REQ-020 SHALL, on reg_re with hit, present shadow[index] on reg_data_out with reg_rvalid=1 one cycle later (latency 1).
REQ-021 SHALL, on a read miss or no read, drive reg_rvalid=0 and reg_data_out=0 in the following cycle.
REQ-022 SHALL, for a read and a write to the same address in the same cycle, return the pre-write value.
REQ-023 SHALL, when commit=1, load every active register from the current shadow value (pre-write for the same cycle) at the edge.
REQ-024 SHALL keep cfg_data_out unchanged between commits regardless of shadow writes.
REQ-025 SHALL assert cfg_update for exactly one cycle, in the first cycle the committed values appear on cfg_data_out.
REQ-026 SHALL set pending on any hit write and clear it on commit; a write and a commit in the same cycle SHALL leave pending=1.
REQ-027 SHALL assert cfg_update on every commit, including back-to-back commits and commits with pending=0.
REQ-028 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: shadow=RST_VAL, active=RST_VAL (cfg_data_out={NREG{RST_VAL}}), reg_data_out=0, reg_rvalid=0, cfg_update=0, pending=0.
REQ-030 SHALL discard any read, write or commit in progress when reset asserts mid-operation; none takes effect after release.
REQ-031 SHALL accept a write in the first clock edge after rst_n rises.

Verification
REQ-032 SHALL cover: reset release, read all NREG addresses -> reg_data_out=RST_VAL, rvalid=1 each, cfg_data_out all RST_VAL.
REQ-033 SHALL cover: write 0xA5A5 to BASE_ADDR+1 -> pending=1 next cycle, cfg_data_out reg1 still RST_VAL; read returns 0xA5A5 one cycle later.
REQ-034 SHALL cover: commit after REQ-033 -> next cycle cfg_data_out reg1=0xA5A5, cfg_update=1 for one cycle, pending=0.
REQ-035 SHALL cover: write 0x1234 to reg0 together with commit (shadow reg0=0x0001) -> active reg0=0x0001, shadow reg0=0x1234, pending=1.
REQ-036 SHALL cover: write/read to BASE_ADDR+NREG and BASE_ADDR-1 (BASE_ADDR>0) -> no state change, rvalid=0, reg_data_out=0.
REQ-037 SHALL cover: rst_n pulsed low between a write and a commit -> all registers RST_VAL, pending=0, no cfg_update after release.
